lfsr_random_gen: RTL and testbench

LFSR_RANDOM_GEN -- requirements
Module: lfsr_random_gen

---
 rtl/lfsr_random_gen_pkg.sv | 21 ++
 rtl/lfsr_random_gen_if.sv | 28 ++
 rtl/lfsr_step_core.sv | 34 +++
 rtl/lfsr_random_gen.sv | 110 +++++++++++
 tb/tb_lfsr_random_gen.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/lfsr_random_gen_pkg.sv
// Shared definitions for the LFSR random generator.
// Holds the FSM state enum, the default seed and tap mask, and the
// single-step Galois LFSR function used by the step core.
package lfsr_random_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWarmup,
    StRun
  } state_e;

  localparam logic [31:0] LfsrDefaultSeed = 32'h0000_0001;
  // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LfsrTaps        = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] value, input logic [31:0] taps);
    return value[0] ? ((value >> 1) ^ taps) : (value >> 1);
  endfunction

endpackage

// File: rtl/lfsr_random_gen_if.sv
// Control/data bundle between the HPS PIOs and the LFSR random generator.
//   ctrl         : bit0 enable (level), bit1 reseed request (rising edge)
//   seed         : reseed value
//   random_out   : latest random word
//   valid        : a word has been produced since the last reseed/reset
//   sample_count : words produced since the last reseed (wrapping)
//   busy         : generator is loading or warming up
// master = HPS side, slave = generator.
interface lfsr_random_gen_if;

  logic [1:0]  ctrl;
  logic [31:0] seed;
  logic [31:0] random_out;
  logic        valid;
  logic [15:0] sample_count;
  logic        busy;

  modport master (
    output ctrl, seed,
    input  random_out, valid, sample_count, busy
  );

  modport slave (
    input  ctrl, seed,
    output random_out, valid, sample_count, busy
  );

endinterface

// File: rtl/lfsr_step_core.sv
// LFSR register with load mux and step logic.
//   clk, reset_n : clock and asynchronous active-low reset
//   load         : load load_value (zero replaced by DEFAULT_SEED)
//   step         : advance one Galois step (ignored while loading)
//   load_value   : seed to load
//   lfsr_next    : value the register takes on the next step
module lfsr_step_core import lfsr_random_gen_pkg::*; #(
  parameter logic [31:0] DEFAULT_SEED = LfsrDefaultSeed,
  parameter logic [31:0] TAPS         = LfsrTaps
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] load_value,
  output logic [31:0] lfsr_next
);

  logic [31:0] lfsr_q;

  assign lfsr_next = lfsr_step(lfsr_q, TAPS);

  // A zero seed would lock the LFSR at zero forever.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= DEFAULT_SEED;
    end else if (load) begin
      lfsr_q <= (load_value == '0) ? DEFAULT_SEED : load_value;
    end else if (step) begin
      lfsr_q <= lfsr_next;
    end
  end

endmodule

// File: rtl/lfsr_random_gen.sv
// LFSR random word generator for the HPS PIO interface.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus          : slave side of lfsr_random_gen_if (ctrl/seed in,
//                  random_out/valid/sample_count/busy out)
// A rising edge on ctrl[1] reloads the seed, discards WARMUP_CYCLES
// steps, then produces one word per cycle while ctrl[0] is high.
module lfsr_random_gen import lfsr_random_gen_pkg::*; #(
  parameter logic [31:0] DEFAULT_SEED  = LfsrDefaultSeed,
  parameter int unsigned WARMUP_CYCLES = 32,
  parameter logic [31:0] TAPS          = LfsrTaps
) (
  input logic               clk,
  input logic               reset_n,
  lfsr_random_gen_if.slave  bus
);

  localparam logic [7:0] WarmInit = 8'(WARMUP_CYCLES);

  state_e      state_q;
  logic [31:0] random_out_q;
  logic        valid_q;
  logic [15:0] count_q;
  logic        busy_q;
  logic        reseed_hist_q;
  logic [7:0]  warm_cnt_q;

  logic        enable;
  logic        reseed;
  logic        core_load;
  logic        core_step;
  logic [31:0] lfsr_next;

  assign enable    = bus.ctrl[0];
  assign reseed    = bus.ctrl[1] & ~reseed_hist_q;
  assign core_load = (state_q == StLoad);
  // A reseed edge pre-empts any step on the same edge.
  assign core_step = !reseed && ((state_q == StWarmup) || (state_q == StRun && enable));

  lfsr_step_core #(
    .DEFAULT_SEED (DEFAULT_SEED),
    .TAPS         (TAPS)
  ) u_core (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (core_load),
    .step       (core_step),
    .load_value (bus.seed),
    .lfsr_next  (lfsr_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      random_out_q  <= '0;
      valid_q       <= 1'b0;
      count_q       <= '0;
      busy_q        <= 1'b0;
      reseed_hist_q <= 1'b0;
      warm_cnt_q    <= '0;
    end else begin
      reseed_hist_q <= bus.ctrl[1];
      if (reseed) begin
        // Clear early so valid/count already read zero during LOAD.
        state_q <= StLoad;
        busy_q  <= 1'b1;
        valid_q <= 1'b0;
        count_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (enable) state_q <= StRun;
          end
          StLoad: begin
            warm_cnt_q <= WarmInit;
            valid_q    <= 1'b0;
            count_q    <= '0;
            if (WarmInit != 8'd0) begin
              state_q <= StWarmup;
            end else begin
              state_q <= enable ? StRun : StIdle;
              busy_q  <= 1'b0;
            end
          end
          StWarmup: begin
            warm_cnt_q <= warm_cnt_q - 8'd1;
            if (warm_cnt_q == 8'd1) begin
              state_q <= enable ? StRun : StIdle;
              busy_q  <= 1'b0;
            end
          end
          StRun: begin
            if (enable) begin
              random_out_q <= lfsr_next;
              valid_q      <= 1'b1;
              count_q      <= count_q + 16'd1;
            end else begin
              state_q <= StIdle;
            end
          end
        endcase
      end
    end
  end

  assign bus.random_out   = random_out_q;
  assign bus.valid        = valid_q;
  assign bus.sample_count = count_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_lfsr_random_gen.sv
module tb_lfsr_random_gen;

  logic        clk;
  logic        reset_n;
  logic [1:0]  ctrl;
  logic [31:0] seed;

  int unsigned n_tests;
  int unsigned n_failed;

  lfsr_random_gen_if bus0 ();
  lfsr_random_gen_if bus3 ();

  assign bus0.ctrl = ctrl;
  assign bus0.seed = seed;
  assign bus3.ctrl = ctrl;
  assign bus3.seed = seed;

  lfsr_random_gen #(
    .DEFAULT_SEED  (32'h0000_0001),
    .WARMUP_CYCLES (0),
    .TAPS          (32'h8020_0003)
  ) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  lfsr_random_gen #(
    .DEFAULT_SEED  (32'h0000_0001),
    .WARMUP_CYCLES (3),
    .TAPS          (32'h8020_0003)
  ) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    reset_n  = 1'b0;
    ctrl     = 2'b00;
    seed     = 32'h0000_0001;

    // Reset held with ctrl toggling.
    ctrl = 2'b11; tick();
    ctrl = 2'b01; tick();
    ctrl = 2'b10; tick();
    check("rst_out",   bus0.random_out,          32'h0);
    check("rst_valid", 32'(bus0.valid),          32'h0);
    check("rst_busy",  32'(bus0.busy),           32'h0);
    check("rst_cnt",   32'(bus0.sample_count),   32'h0);
    check("rst_busy3", 32'(bus3.busy),           32'h0);
    check("rst_out3",  bus3.random_out,          32'h0);

    reset_n = 1'b1;
    ctrl    = 2'b00;
    tick();
    check("idle_out",   bus0.random_out, 32'h0);
    check("idle_valid", 32'(bus0.valid), 32'h0);

    // Known sequence from seed 1.
    ctrl = 2'b11; tick();  // E0: LOAD
    check("seq_busy_e0",  32'(bus0.busy), 32'h1);
    check("wu_busy_e0",   32'(bus3.busy), 32'h1);
    ctrl = 2'b01; tick();  // E1: loaded
    check("seq_busy_e1",  32'(bus0.busy),  32'h0);
    check("seq_valid_e1", 32'(bus0.valid), 32'h0);
    check("wu_busy_e1",   32'(bus3.busy),  32'h1);
    tick();                // E2
    check("seq_out1",    bus0.random_out,        32'h8020_0003);
    check("seq_cnt1",    32'(bus0.sample_count), 32'd1);
    check("seq_valid1",  32'(bus0.valid),        32'h1);
    check("wu_busy_e2",  32'(bus3.busy),         32'h1);
    check("wu_valid_e2", 32'(bus3.valid),        32'h0);
    tick();                // E3
    check("seq_out2",   bus0.random_out,        32'hC030_0002);
    check("seq_cnt2",   32'(bus0.sample_count), 32'd2);
    check("wu_busy_e3", 32'(bus3.busy),         32'h1);
    tick();                // E4
    check("seq_out3",    bus0.random_out,        32'h6018_0001);
    check("seq_cnt3",    32'(bus0.sample_count), 32'd3);
    check("wu_busy_e4",  32'(bus3.busy),         32'h0);
    check("wu_valid_e4", 32'(bus3.valid),        32'h0);
    tick();                // E5
    // Three discarded steps: 80200003, C0300002, 60180001; first output is the fourth.
    check("wu_out1",   bus3.random_out,        32'hB02C_0003);
    check("wu_cnt1",   32'(bus3.sample_count), 32'd1);
    check("wu_valid1", 32'(bus3.valid),        32'h1);

    // Zero seed falls back to the default seed.
    seed = 32'h0;
    ctrl = 2'b11; tick();
    ctrl = 2'b01; tick();
    tick();
    check("zs_out1", bus0.random_out, 32'h8020_0003);
    check("zs_nz",   32'(bus0.random_out != 32'h0), 32'h1);
    tick();
    check("zs_out2", bus0.random_out, 32'hC030_0002);
    tick();
    check("zs_out3", bus0.random_out, 32'h6018_0001);
    check("zs_cnt3", 32'(bus0.sample_count), 32'd3);

    // Reseed during RUN with ctrl[1] held for ten cycles.
    seed = 32'h1234_5678;
    ctrl = 2'b11; tick();  // E0
    check("rs_valid_e0", 32'(bus0.valid),        32'h0);
    check("rs_cnt_e0",   32'(bus0.sample_count), 32'd0);
    check("rs_busy_e0",  32'(bus0.busy),         32'h1);
    tick();                // E1
    check("rs_valid_e1", 32'(bus0.valid),        32'h0);
    check("rs_cnt_e1",   32'(bus0.sample_count), 32'd0);
    tick();                // E2
    check("rs_out1",  bus0.random_out,        32'h091A_2B3C);
    check("rs_cnt1",  32'(bus0.sample_count), 32'd1);
    check("rs_valid", 32'(bus0.valid),        32'h1);
    tick();                // E3
    check("rs_out2", bus0.random_out, 32'h048D_159E);
    repeat (6) tick();     // E4..E9, ctrl[1] still high
    check("rs_cnt_e9", 32'(bus0.sample_count), 32'd8);
    check("rs_busy_e9", 32'(bus0.busy), 32'h0);
    ctrl = 2'b01; tick();
    check("rs_cnt_e10", 32'(bus0.sample_count), 32'd9);

    // Enable dropped mid-RUN freezes outputs and the LFSR.
    seed = 32'h0000_0001;
    ctrl = 2'b00; tick();
    ctrl = 2'b11; tick();
    ctrl = 2'b01; tick();
    tick();
    check("fz_out0", bus0.random_out, 32'h8020_0003);
    ctrl = 2'b00;
    repeat (3) tick();
    check("fz_out",   bus0.random_out,        32'h8020_0003);
    check("fz_cnt",   32'(bus0.sample_count), 32'd1);
    check("fz_valid", 32'(bus0.valid),        32'h1);
    ctrl = 2'b01; tick();  // IDLE -> RUN, no step
    check("fz_resume0", bus0.random_out, 32'h8020_0003);
    tick();
    check("fz_resume1", bus0.random_out, 32'hC030_0002);
    check("fz_cnt2",    32'(bus0.sample_count), 32'd2);

    // Reset asserted mid-WARMUP takes effect without a clock.
    ctrl = 2'b11; tick();
    ctrl = 2'b01; tick();
    tick();
    check("mw_busy", 32'(bus3.busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mw_busy3",  32'(bus3.busy),         32'h0);
    check("mw_valid3", 32'(bus3.valid),        32'h0);
    check("mw_out3",   bus3.random_out,        32'h0);
    check("mw_cnt3",   32'(bus3.sample_count), 32'd0);
    check("mw_out0",   bus0.random_out,        32'h0);
    check("mw_cnt0",   32'(bus0.sample_count), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();                // IDLE -> RUN, no warmup residue
    check("pr_busy3", 32'(bus3.busy), 32'h0);
    tick();
    check("pr_out3", bus3.random_out,        32'h8020_0003);
    check("pr_cnt3", 32'(bus3.sample_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
